// File: rtl/ff_counter_pkg.sv
// Shared definitions for the flip-flop / counter utility block.
// Holds the default sizing and the JK input encoding.
package ff_counter_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int COUNT_MAX_DEF = 40;

    // JK input pair {j,k} decoded as a single code.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_code_e;

endpackage

// File: rtl/ff_counter_if.sv
// Bundle of the flip-flop/counter control inputs and state outputs.
// The master side drives j/k/t/initiate; the slave side (the unit) returns state.
interface ff_counter_if
    import ff_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             j;
    logic             k;
    logic             t;
    logic             initiate;
    logic             jk_q;
    logic             jk_q_n;
    logic             t_q;
    logic             t_q_n;
    logic [WIDTH-1:0] count;
    logic             done;

    modport master (
        output j, k, t, initiate,
        input  jk_q, jk_q_n, t_q, t_q_n, count, done
    );

    modport slave (
        input  j, k, t, initiate,
        output jk_q, jk_q_n, t_q, t_q_n, count, done
    );

endinterface

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with synchronous active-high set to q=1.
// q_n is the combinational complement, never a separate register.
module jk_ff_cell
    import ff_counter_pkg::*;
(
    input  logic clk,
    input  logic set,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    logic     q_r;
    logic     q_next_s;
    jk_code_e code_s;

    // Next-state decode of the JK input pair.
    always_comb begin
        code_s   = jk_code_e'({j, k});
        q_next_s = q_r;
        case (code_s)
            HOLD:    q_next_s = q_r;
            RESET:   q_next_s = 1'b0;
            SET:     q_next_s = 1'b1;
            TOGGLE:  q_next_s = ~q_r;
            default: q_next_s = q_r;
        endcase
    end

    // State register; set forces q high and overrides j/k.
    always_ff @(posedge clk) begin
        if (set) begin
            q_r <= 1'b1;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q   = q_r;
    assign q_n = ~q_r;

endmodule

// File: rtl/ff_counter_unit.sv
// JK flip-flop, T flip-flop and saturating up-counter sharing one clock and reset.
// The T function reuses the JK cell with j=k=t.
module ff_counter_unit
    import ff_counter_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int COUNT_MAX = COUNT_MAX_DEF
) (
    input  logic        clk,
    input  logic        set,
    ff_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(COUNT_MAX);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic             jk_q_s;
    logic             jk_q_n_s;
    logic             t_q_s;
    logic             t_q_n_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    jk_ff_cell u_jk (
        .clk (clk),
        .set (set),
        .j   (bus.j),
        .k   (bus.k),
        .q   (jk_q_s),
        .q_n (jk_q_n_s)
    );

    jk_ff_cell u_t (
        .clk (clk),
        .set (set),
        .j   (bus.t),
        .k   (bus.t),
        .q   (t_q_s),
        .q_n (t_q_n_s)
    );

    // Counter next value: clear when idle, increment, then saturate at the terminal count.
    always_comb begin
        count_next_s = count_r;
        if (!bus.initiate) begin
            count_next_s = ZERO_C;
        end else if (count_r < MAX_C) begin
            count_next_s = count_r + ONE_C;
        end else begin
            count_next_s = MAX_C;
        end
    end

    // Counter register; set clears it regardless of initiate.
    always_ff @(posedge clk) begin
        if (set) begin
            count_r <= ZERO_C;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign bus.jk_q   = jk_q_s;
    assign bus.jk_q_n = jk_q_n_s;
    assign bus.t_q    = t_q_s;
    assign bus.t_q_n  = t_q_n_s;
    assign bus.count  = count_r;
    assign bus.done   = (count_r == MAX_C);

endmodule

// File: tb/tb_ff_counter_unit.sv
// Directed scoreboard bench for ff_counter_unit: stimulus pushes expected state,
// a negedge monitor pops and compares.
module tb_ff_counter_unit;

    typedef struct {
        string       name;
        logic        jk;
        logic        t;
        logic [15:0] cnt;
        logic        done;
    } exp_t;

    logic clk;
    logic set;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    ff_counter_if #(.WIDTH(16)) bus ();

    ff_counter_unit #(.WIDTH(16), .COUNT_MAX(40)) dut (
        .clk (clk),
        .set (set),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One edge of stimulus followed by pushing the hand-computed expected state.
    task automatic step(input logic s, input logic jj, input logic kk, input logic tt,
                        input logic ii, input logic e_jk, input logic e_t,
                        input int e_cnt, input string nm);
        exp_t e;
        set          = s;
        bus.j        = jj;
        bus.k        = kk;
        bus.t        = tt;
        bus.initiate = ii;
        @(posedge clk);
        e.name = nm;
        e.jk   = e_jk;
        e.t    = e_t;
        e.cnt  = 16'(e_cnt);
        e.done = (e_cnt == 40);
        sb.push_back(e);
        #1;
    endtask

    // Monitor: compare every presented expectation against the outputs after the edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [20:0] act;
            logic [20:0] req;
            e   = sb.pop_front();
            act = {bus.jk_q, bus.jk_q_n, bus.t_q, bus.t_q_n, bus.done, bus.count};
            req = {e.jk, ~e.jk, e.t, ~e.t, e.done, e.cnt};
            n_cmp++;
            if (act !== req) begin
                n_bad++;
                $display("FAIL %s: got jk_q=%b jk_q_n=%b t_q=%b t_q_n=%b done=%b count=%0d, want jk_q=%b jk_q_n=%b t_q=%b t_q_n=%b done=%b count=%0d",
                         e.name, bus.jk_q, bus.jk_q_n, bus.t_q, bus.t_q_n, bus.done, bus.count,
                         e.jk, ~e.jk, e.t, ~e.t, e.done, e.cnt);
            end
        end
    end

    logic [1:0] jk_vec [7];
    logic       jk_exp [7];
    logic       t_vec  [8];
    logic       t_exp  [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        jk_vec = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        jk_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t_vec  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        t_exp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        set = 1'b1;
        bus.j = 1'b0;
        bus.k = 1'b0;
        bus.t = 1'b0;
        bus.initiate = 1'b0;
        #2;

        // Reset with random control inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'b1, 1'b1, 0, $sformatf("reset%0d", i));
        end

        // JK truth table
        for (int i = 0; i < 7; i++) begin
            logic [1:0] v;
            v = jk_vec[i];
            step(1'b0, v[1], v[0], 1'b0, 1'b0, jk_exp[i], 1'b1, 0, $sformatf("jk%0d", i));
        end

        // T flip-flop
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "reset_t");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, t_vec[i], 1'b0, 1'b1, t_exp[i], 0, $sformatf("t%0d", i));
        end

        // Counter run
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "reset_cnt");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, $sformatf("idle%0d", i));
        end
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, i, $sformatf("run%0d", i));
        end

        // Saturation
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "clr_sat");
        for (int i = 1; i <= 45; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, (i < 40) ? i : 40,
                 $sformatf("sat%0d", i));
        end

        // Mid-run clear then set priority
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "clr_mid");
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, i, $sformatf("mid%0d", i));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "drop_at17");
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, i, $sformatf("restart%0d", i));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "set_at5");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, "after_set");

        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
